bcd_time_loader: RTL and testbench



---
 rtl/bcd_time_loader_pkg.sv | 25 ++
 rtl/bcd_time_loader_bcd_pair_to_bin.sv | 29 ++
 rtl/bcd_time_loader.sv | 154 +++++++++++++++
 tb/tb_bcd_time_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_loader_pkg.sv
// Shared types and limits for the BCD time loader: state encoding, digit width
// default and the per-field legality bounds.
package bcd_time_loader_pkg;

  localparam int DIGIT_W_DEF   = 5;
  localparam int HOURS_MAX_DEF = 23;
  localparam int MAX_TENS_MS   = 5;
  localparam int BCD_MAX       = 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CONV = S_CONV,
    ST_DONE = S_DONE
  } state_t;

  // field_idx values, converted in this order
  localparam logic [1:0] IDX_H = 2'd0;
  localparam logic [1:0] IDX_M = 2'd1;
  localparam logic [1:0] IDX_S = 2'd2;

endpackage

// File: rtl/bcd_time_loader_bcd_pair_to_bin.sv
// Combinational tens/ones BCD pair to binary converter with legality check
// against per-field tens and value limits.
module bcd_pair_to_bin
  import bcd_time_loader_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic [DIGIT_W-1:0] i_tens,
  input  logic [DIGIT_W-1:0] i_ones,
  input  logic [DIGIT_W-1:0] i_max_tens,
  input  logic [6:0]         i_max_value,
  output logic [6:0]         o_value,
  output logic               o_invalid
);

  localparam int SUM_W = (DIGIT_W + 4 > 7) ? DIGIT_W + 4 : 7;

  logic [SUM_W-1:0] w_sum;

  // Full-width sum so the value limit is judged before truncation
  assign w_sum = (SUM_W'(i_tens) << 3) + (SUM_W'(i_tens) << 1) + SUM_W'(i_ones);

  assign o_value   = w_sum[6:0];
  assign o_invalid = (i_tens > DIGIT_W'(BCD_MAX)) ||
                     (i_ones > DIGIT_W'(BCD_MAX)) ||
                     (i_tens > i_max_tens)        ||
                     (w_sum  > SUM_W'(i_max_value));

endmodule

// File: rtl/bcd_time_loader.sv
// Converts captured HH:MM:SS BCD digits to binary, one field per clock, and
// presents the result through a start/done/ack responder handshake.
module bcd_time_loader
  import bcd_time_loader_pkg::*;
#(
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int HOURS_MAX = HOURS_MAX_DEF
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ack,
  input  logic [DIGIT_W-1:0] hours_tens,
  input  logic [DIGIT_W-1:0] hours_ones,
  input  logic [DIGIT_W-1:0] minutes_tens,
  input  logic [DIGIT_W-1:0] minutes_ones,
  input  logic [DIGIT_W-1:0] seconds_tens,
  input  logic [DIGIT_W-1:0] seconds_ones,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [5:0]         hours,
  output logic [6:0]         minutes,
  output logic [6:0]         seconds
);

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]         r_idx;
  logic               r_err;
  logic               r_error;
  logic [DIGIT_W-1:0] r_ht, r_ho, r_mt, r_mo, r_st, r_so;
  logic [5:0]         r_stage_h;
  logic [6:0]         r_stage_m;
  logic [5:0]         r_hours;
  logic [6:0]         r_minutes;
  logic [6:0]         r_seconds;

  logic [DIGIT_W-1:0] w_tens, w_ones, w_max_tens;
  logic [6:0]         w_max_value;
  logic [6:0]         w_value;
  logic               w_invalid;

  always_comb begin
    w_tens      = r_ht;
    w_ones      = r_ho;
    w_max_tens  = DIGIT_W'(BCD_MAX);
    w_max_value = 7'(HOURS_MAX);
    case (r_idx)
      IDX_M: begin
        w_tens      = r_mt;
        w_ones      = r_mo;
        w_max_tens  = DIGIT_W'(MAX_TENS_MS);
        w_max_value = 7'd59;
      end
      IDX_S: begin
        w_tens      = r_st;
        w_ones      = r_so;
        w_max_tens  = DIGIT_W'(MAX_TENS_MS);
        w_max_value = 7'd59;
      end
      default: ;
    endcase
  end

  bcd_pair_to_bin #(.DIGIT_W(DIGIT_W)) u_conv (
    .i_tens      (w_tens),
    .i_ones      (w_ones),
    .i_max_tens  (w_max_tens),
    .i_max_value (w_max_value),
    .o_value     (w_value),
    .o_invalid   (w_invalid)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)          w_state_nxt = ST_CONV;
      ST_CONV: if (r_idx == IDX_S) w_state_nxt = ST_DONE;
      ST_DONE: if (ack)            w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= IDX_H;
      r_err     <= 1'b0;
      r_error   <= 1'b0;
      r_ht      <= '0;
      r_ho      <= '0;
      r_mt      <= '0;
      r_mo      <= '0;
      r_st      <= '0;
      r_so      <= '0;
      r_stage_h <= '0;
      r_stage_m <= '0;
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ht  <= hours_tens;
            r_ho  <= hours_ones;
            r_mt  <= minutes_tens;
            r_mo  <= minutes_ones;
            r_st  <= seconds_tens;
            r_so  <= seconds_ones;
            r_idx <= IDX_H;
            r_err <= 1'b0;
          end
        end
        ST_CONV: begin
          r_err <= r_err | w_invalid;
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            IDX_H: r_stage_h <= w_value[5:0];
            IDX_M: r_stage_m <= w_value;
            default: begin
              // Seconds come straight from the converter on the final edge
              r_idx <= IDX_H;
              if (r_err | w_invalid) begin
                r_error <= 1'b1;
              end else begin
                r_error   <= 1'b0;
                r_hours   <= r_stage_h;
                r_minutes <= r_stage_m;
                r_seconds <= w_value;
              end
            end
          endcase
        end
        ST_DONE: if (ack) r_error <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign error   = r_error;
  assign hours   = r_hours;
  assign minutes = r_minutes;
  assign seconds = r_seconds;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Scoreboard bench for bcd_time_loader: expectations are queued at capture and
// compared when done rises.
module tb_bcd_time_loader;

  localparam int DW = 5;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          start, ack;
  logic [DW-1:0] ht, ho, mt, mo, st, so;
  logic          busy, done, error;
  logic [5:0]    hours;
  logic [6:0]    minutes, seconds;

  typedef struct {
    int h;
    int m;
    int s;
    int e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mh = 0, mm = 0, ms = 0;

  always #5 sys_clk = ~sys_clk;

  bcd_time_loader #(.DIGIT_W(DW), .HOURS_MAX(23)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .start        (start),
    .ack          (ack),
    .hours_tens   (ht),
    .hours_ones   (ho),
    .minutes_tens (mt),
    .minutes_ones (mo),
    .seconds_tens (st),
    .seconds_ones (so),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_digits(input int a, input int b, input int c,
                            input int d, input int e, input int f);
    ht = DW'(a); ho = DW'(b); mt = DW'(c); mo = DW'(d); st = DW'(e); so = DW'(f);
  endtask

  task automatic push_expect(input int a, input int b, input int c,
                             input int d, input int e, input int f);
    bit ok;
    ok = (a <= 9) && (b <= 9) && (c <= 5) && (d <= 9) && (e <= 5) && (f <= 9)
         && ((a * 10 + b) <= 23);
    if (ok) begin
      mh = a * 10 + b;
      mm = c * 10 + d;
      ms = e * 10 + f;
    end
    sb.push_back('{mh, mm, ms, ok ? 0 : 1});
  endtask

  task automatic run_conv(input int a, input int b, input int c,
                          input int d, input int e, input int f,
                          input int hold, input bit disturb, input bit start_ack);
    int   edges;
    exp_t x;
    set_digits(a, b, c, d, e, f);
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    push_expect(a, b, c, d, e, f);
    check("busy_after_capture", busy, 1);
    if (disturb) begin
      set_digits(0, 1, 0, 2, 0, 3);
      start = 1'b1;
    end
    edges = 0;
    while (!done && edges < 10) begin
      @(posedge sys_clk); #1;
      edges++;
      start = 1'b0;
    end
    check("latency", edges, 3);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      check("hours", hours, x.h);
      check("minutes", minutes, x.m);
      check("seconds", seconds, x.s);
      check("error", error, x.e);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge sys_clk); #1;
      check("done_held", done, 1);
      check("error_held", error, x.e);
    end
    ack   = 1'b1;
    start = start_ack;
    @(posedge sys_clk); #1;
    ack   = 1'b0;
    start = 1'b0;
    check("done_after_ack", done, 0);
    check("busy_after_ack", busy, 0);
    check("error_after_ack", error, 0);
    check("hours_hold_after_ack", hours, x.h);
    if (start_ack) begin
      repeat (4) @(posedge sys_clk);
      #1;
      check("no_conv_busy", busy, 0);
      check("no_conv_done", done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    set_digits(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_hours", hours, 0);
    check("rst_minutes", minutes, 0);
    check("rst_seconds", seconds, 0);
    #11 rst_n = 1'b1;
    @(posedge sys_clk); #1;

    run_conv(1, 2, 3, 4, 5, 6, 10, 1'b0, 1'b0);
    run_conv(2, 3, 5, 9, 5, 9, 1, 1'b0, 1'b0);
    run_conv(0, 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);
    run_conv(1, 2, 3, 4, 5, 6, 1, 1'b0, 1'b0);
    run_conv(2, 4, 0, 0, 0, 0, 1, 1'b0, 1'b0);
    run_conv(1, 2, 6, 4, 5, 6, 1, 1'b0, 1'b0);
    run_conv(1, 2, 3, 4, 5, 10, 1, 1'b0, 1'b0);
    run_conv(1, 9, 4, 7, 0, 8, 1, 1'b1, 1'b0);
    run_conv(2, 0, 1, 5, 3, 0, 2, 1'b0, 1'b1);

    // ack toggling in IDLE must not start anything
    for (int i = 0; i < 4; i++) begin
      ack = ~ack;
      @(posedge sys_clk); #1;
      check("idle_ack_done", done, 0);
      check("idle_ack_busy", busy, 0);
    end
    ack = 1'b0;

    // Asynchronous reset in the middle of a conversion
    set_digits(0, 7, 0, 8, 0, 9);
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_hours", hours, 0);
    check("midrst_minutes", minutes, 0);
    check("midrst_seconds", seconds, 0);
    mh = 0; mm = 0; ms = 0;
    @(posedge sys_clk); #2;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("post_rst_idle", busy, 0);
    run_conv(0, 9, 4, 5, 3, 3, 1, 1'b0, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
